// File: rtl/data_mem_banked_if.sv
// Request/response bus for the banked data memory: one request channel with
// ready/valid acceptance and a single-cycle response pulse.
interface data_mem_banked_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MODE_W = 3;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [MODE_W-1:0] req_mode;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_mode, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_mode, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_banked.sv
// Byte-lane data memory with sub-word loads/stores, selectable endianness and
// optional two-beat handling of accesses that are misaligned.
module data_mem_banked #(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned BIG_ENDIAN     = 1,
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_banked_if.slave bus
);
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]   addr_q, wdata_q, word0_q, word0_d;
    logic [2:0]    mode_q;
    logic          we_q;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   cur_addr, cur_wdata;
    logic [2:0]    cur_mode, size;
    logic          cur_we, sx, misal, req_err;
    logic [1:0]    off;
    logic [32:0]   last_byte;
    logic [7:0]    lane_en;
    logic [63:0]   lane_wd;
    logic [AW-1:0] idx0, idx1;
    logic [31:0]   rd_w0, rd_w1;
    logic          accept, wr_lo, wr_hi;

    // Lanes 0..3 live in word N, lanes 4..7 in word N+1.
    function automatic logic [7:0] lane_mask(input logic [1:0] o, input logic [2:0] sz);
        logic [7:0] m;
        m = '0;
        for (int p = 0; p < 8; p++)
            m[p] = (p >= int'(o)) && (p < int'(o) + int'(sz));
        return m;
    endfunction

    function automatic int datum_byte(input int k, input logic [2:0] sz);
        return (BIG_ENDIAN != 0) ? int'(sz) - 1 - k : k;
    endfunction

    function automatic logic [63:0] place_store(input logic [31:0] wd, input logic [1:0] o,
                                                input logic [2:0] sz);
        logic [63:0] w;
        w = '0;
        for (int p = 0; p < 8; p++)
            if ((p >= int'(o)) && (p < int'(o) + int'(sz)))
                w[8*p +: 8] = wd[8*datum_byte(p - int'(o), sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_data(input logic [63:0] win, input logic [1:0] o,
                                              input logic [2:0] sz, input logic sgn);
        logic [31:0] d;
        d = '0;
        for (int p = 0; p < 8; p++)
            if ((p >= int'(o)) && (p < int'(o) + int'(sz)))
                d[8*datum_byte(p - int'(o), sz) +: 8] = win[8*p +: 8];
        case (sz)
            3'd1:    return sgn ? {{24{d[7]}}, d[7:0]}   : {24'h0, d[7:0]};
            3'd2:    return sgn ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Access decode; in SPLIT the captured request drives beat 2.
    always_comb begin
        cur_addr  = bus.req_addr;
        cur_mode  = bus.req_mode;
        cur_we    = bus.req_we;
        cur_wdata = bus.req_wdata;
        if (state_q == SPLIT) begin
            cur_addr  = addr_q;
            cur_mode  = mode_q;
            cur_we    = we_q;
            cur_wdata = wdata_q;
        end
        size = 3'd4;
        case (cur_mode)
            3'b000, 3'b011: size = 3'd1;
            3'b001, 3'b100: size = 3'd2;
            default:        size = 3'd4;
        endcase
        sx        = (cur_mode == 3'b000) || (cur_mode == 3'b001);
        off       = cur_addr[1:0];
        misal     = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0));
        last_byte = {1'b0, cur_addr} + 33'(size) - 33'd1;
        req_err   = (cur_mode > 3'b100)
                  || (cur_we && ((cur_mode == 3'b011) || (cur_mode == 3'b100)))
                  || (last_byte >= BYTE_LIMIT)
                  || (misal && (MISALIGN_SPLIT == 0));
        lane_en   = lane_mask(off, size);
        lane_wd   = place_store(cur_wdata, off, size);
        idx0      = AW'(cur_addr[31:2]);
        idx1      = AW'(cur_addr[31:2] + 30'd1);
        rd_w0     = mem[idx0];
        rd_w1     = mem[idx1];
    end

    // Next state, response and write strobes.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        word0_d     = word0_q;
        wr_lo       = 1'b0;
        wr_hi       = 1'b0;
        accept      = bus.req_valid && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (misal) begin
                        state_d = SPLIT;
                        word0_d = rd_w0;
                        wr_lo   = cur_we;
                    end else begin
                        rsp_valid_d = 1'b1;
                        wr_lo       = cur_we;
                        if (!cur_we)
                            rsp_rdata_d = load_data({32'h0, rd_w0}, off, size, sx);
                    end
                end
            end
            SPLIT: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                wr_hi       = cur_we;
                if (!cur_we)
                    rsp_rdata_d = load_data({rd_w1, word0_q}, off, size, sx);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture and byte-lane writes; reset blocks both beats' writes.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr;
            mode_q  <= bus.req_mode;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
        end
        word0_q <= word0_d;
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                if (wr_lo && lane_en[p])
                    mem[idx0][8*p +: 8] <= lane_wd[8*p +: 8];
                if (wr_hi && lane_en[p+4])
                    mem[idx1][8*p +: 8] <= lane_wd[8*(p+4) +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_banked.sv
// Directed scoreboard bench for data_mem_banked across three configurations.
module tb_data_mem_banked;
    localparam logic [2:0] M_B  = 3'b000;
    localparam logic [2:0] M_H  = 3'b001;
    localparam logic [2:0] M_W  = 3'b010;
    localparam logic [2:0] M_BU = 3'b011;
    localparam logic [2:0] M_HU = 3'b100;
    localparam logic [2:0] M_RS = 3'b101;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    data_mem_banked_if ifa ();
    data_mem_banked_if ifb ();
    data_mem_banked_if ifc ();

    data_mem_banked #(.DEPTH(256), .BIG_ENDIAN(1), .MISALIGN_SPLIT(1))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    data_mem_banked #(.DEPTH(256), .BIG_ENDIAN(0), .MISALIGN_SPLIT(0))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));
    data_mem_banked #(.DEPTH(4), .BIG_ENDIAN(1), .MISALIGN_SPLIT(1))
        dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        case (d)
            0:       return ifa.req_ready;
            1:       return ifb.req_ready;
            default: return ifc.req_ready;
        endcase
    endfunction

    task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] wd);
        case (d)
            0: begin ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_mode = m; ifa.req_wdata = wd; end
            1: begin ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_mode = m; ifb.req_wdata = wd; end
            default: begin ifc.req_valid = v; ifc.req_we = we; ifc.req_addr = a; ifc.req_mode = m; ifc.req_wdata = wd; end
        endcase
    endtask

    // Present one request, wait (bounded) for acceptance, queue its expectation.
    task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [2:0] m,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, input bit exp_rsp, input string tag);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        drive(d, 1'b1, we, a, m, wd);
        while (rdy(d) !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w >= 8) chk32({tag, "_ready_timeout"}, 32'(rdy(d)), 32'd1);
        if (exp_rsp) begin
            e.tag = tag; e.rdata = er; e.err = ee; e.due = cyc + 1 + lat;
            case (d)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
        end
    endtask

    task automatic idle_all();
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
    endtask

    task automatic mon(input int d, input logic v, input logic [31:0] rd, input logic er);
        exp_t e;
        int   n;
        case (d)
            0:       n = q_a.size();
            1:       n = q_b.size();
            default: n = q_c.size();
        endcase
        if (v !== 1'b1) begin
            chk32($sformatf("d%0d_idle_rdata", d), rd, 32'h0);
            chk32($sformatf("d%0d_idle_err", d), 32'(er), 32'h0);
        end else if (n == 0) begin
            chk32($sformatf("d%0d_spurious_rsp", d), 32'(v), 32'h0);
        end else begin
            case (d)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            chk32({e.tag, "_rdata"}, rd, e.rdata);
            chk32({e.tag, "_err"}, 32'(er), 32'(e.err));
            chk32({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ifa.rsp_valid, ifa.rsp_rdata, ifa.rsp_err);
            mon(1, ifb.rsp_valid, ifb.rsp_rdata, ifb.rsp_err);
            mon(2, ifc.rsp_valid, ifc.rsp_rdata, ifc.rsp_err);
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        drive(0, 1'b1, 1'b0, 32'h0, M_W, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        chk32("rst_ready_a", 32'(ifa.req_ready), 32'd1);
        chk32("rst_valid_a", 32'(ifa.rsp_valid), 32'd0);
        chk32("rst_ready_b", 32'(ifb.req_ready), 32'd1);
        chk32("rst_valid_b", 32'(ifb.rsp_valid), 32'd0);
        chk32("rst_ready_c", 32'(ifc.req_ready), 32'd1);
        chk32("rst_valid_c", 32'(ifc.rsp_valid), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Big-endian, split-enabled instance.
        issue(0, 1, 32'h10,  M_W,  32'h11223344, 32'h0,        0, 0, 1, "a_st_w10");
        issue(0, 0, 32'h10,  M_B,  32'h0,        32'h00000011, 0, 0, 1, "a_ld_b10");
        issue(0, 0, 32'h12,  M_H,  32'h0,        32'h00003344, 0, 0, 1, "a_ld_h12");
        issue(0, 1, 32'h21,  M_B,  32'h80,       32'h0,        0, 0, 1, "a_st_b21");
        issue(0, 0, 32'h21,  M_B,  32'h0,        32'hFFFFFF80, 0, 0, 1, "a_ld_b21");
        issue(0, 0, 32'h21,  M_BU, 32'h0,        32'h00000080, 0, 0, 1, "a_ld_bu21");
        issue(0, 1, 32'h3,   M_W,  32'hAABBCCDD, 32'h0,        0, 1, 1, "a_st_w3");
        issue(0, 0, 32'h3,   M_W,  32'h0,        32'hAABBCCDD, 0, 1, 1, "a_ld_w3");
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        chk32("a_split_ready_low", 32'(ifa.req_ready), 32'd0);
        issue(0, 0, 32'h3,   M_B,  32'h0,        32'hFFFFFFAA, 0, 0, 1, "a_ld_b3");
        issue(0, 0, 32'h6,   M_BU, 32'h0,        32'h000000DD, 0, 0, 1, "a_ld_bu6");
        issue(0, 0, 32'h11,  M_H,  32'h0,        32'h00002233, 0, 1, 1, "a_ld_h11");
        issue(0, 0, 32'h0,   M_RS, 32'h0,        32'h0,        1, 0, 1, "a_bad_mode");
        issue(0, 1, 32'h40,  M_BU, 32'h5A,       32'h0,        1, 0, 1, "a_st_bu");
        issue(0, 1, 32'h3FC, M_W,  32'hCAFEF00D, 32'h0,        0, 0, 1, "a_st_w3fc");
        issue(0, 0, 32'h3FC, M_W,  32'h0,        32'hCAFEF00D, 0, 0, 1, "a_ld_w3fc");
        issue(0, 0, 32'h3FF, M_H,  32'h0,        32'h0,        1, 0, 1, "a_ld_h3ff");
        issue(0, 1, 32'h3FE, M_W,  32'h01010101, 32'h0,        1, 0, 1, "a_st_w3fe");
        issue(0, 0, 32'h3FC, M_W,  32'h0,        32'hCAFEF00D, 0, 0, 1, "a_ld_w3fc_again");
        issue(0, 1, 32'h30,  M_H,  32'h00008001, 32'h0,        0, 0, 1, "a_st_h30");
        issue(0, 0, 32'h30,  M_H,  32'h0,        32'hFFFF8001, 0, 0, 1, "a_ld_h30");
        issue(0, 0, 32'h30,  M_HU, 32'h0,        32'h00008001, 0, 0, 1, "a_ld_hu30");

        // Reset lands in the SPLIT cycle of a split store.
        issue(0, 1, 32'h8,   M_W,  32'h01020304, 32'h0,        0, 0, 1, "a_pre8");
        issue(0, 1, 32'h4,   M_W,  32'h0,        32'h0,        0, 0, 1, "a_pre4");
        issue(0, 1, 32'h5,   M_W,  32'hDEADBEEF, 32'h0,        0, 1, 0, "a_st_w5");
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, M_W, 32'h0);
        chk32("a_rst_split_ready", 32'(ifa.req_ready), 32'd0);
        rst_a = 1'b0;
        @(negedge clk);
        chk32("a_ready_after_rst", 32'(ifa.req_ready), 32'd1);
        rst_a = 1'b1;
        issue(0, 0, 32'h4,   M_W,  32'h0,        32'h00DEADBE, 0, 0, 1, "a_rst_ld_w4");
        issue(0, 0, 32'h8,   M_BU, 32'h0,        32'h00000001, 0, 0, 1, "a_rst_ld_b8");
        idle_all();

        // Little-endian instance with misaligned accesses faulting.
        issue(1, 0, 32'h2,   M_W,  32'h0,        32'h0,        1, 0, 1, "b_ld_w2");
        issue(1, 1, 32'h0,   M_W,  32'h12345678, 32'h0,        0, 0, 1, "b_st_w0");
        issue(1, 0, 32'h0,   M_W,  32'h0,        32'h12345678, 0, 0, 1, "b_ld_w0");
        issue(1, 0, 32'h0,   M_BU, 32'h0,        32'h00000078, 0, 0, 1, "b_ld_bu0");
        issue(1, 0, 32'h2,   M_H,  32'h0,        32'h00001234, 0, 0, 1, "b_ld_h2");
        issue(1, 0, 32'h3,   M_B,  32'h0,        32'h00000012, 0, 0, 1, "b_ld_b3");
        issue(1, 1, 32'h1,   M_H,  32'hFFFF,     32'h0,        1, 0, 1, "b_st_h1");
        issue(1, 0, 32'h0,   M_W,  32'h0,        32'h12345678, 0, 0, 1, "b_ld_w0_again");
        idle_all();

        // Four-word instance: accesses crossing the top of memory.
        issue(2, 1, 32'hC,   M_W,  32'h55667788, 32'h0,        0, 0, 1, "c_st_wc");
        issue(2, 0, 32'h10,  M_W,  32'h0,        32'h0,        1, 0, 1, "c_ld_w10");
        issue(2, 1, 32'hF,   M_H,  32'hFFFF,     32'h0,        1, 0, 1, "c_st_hf");
        issue(2, 0, 32'hC,   M_W,  32'h0,        32'h55667788, 0, 0, 1, "c_ld_wc");
        issue(2, 0, 32'hF,   M_B,  32'h0,        32'hFFFFFF88, 0, 0, 1, "c_ld_bf");
        issue(2, 0, 32'hE,   M_W,  32'h0,        32'h0,        1, 0, 1, "c_ld_we");
        issue(2, 0, 32'hD,   M_H,  32'h0,        32'h00006677, 0, 1, 1, "c_ld_hd");
        idle_all();

        for (int i = 0; i < 20 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
            @(negedge clk);
        chk32("pending_rsp", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
